// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// sequencer state encoding and the MIPS funct values used by decode.
package muldiv_pkg;

  localparam int MD_XLEN = 32;

  // Operation select driven by decode
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_CALC  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } md_state_e;

  // SPECIAL-opcode funct field values handled by this unit
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // The low two funct bits of mult/multu/div/divu line up with the op encoding
  function automatic logic [1:0] funct_to_op(input logic [5:0] funct);
    return funct[1:0];
  endfunction

  function automatic logic is_muldiv_funct(input logic [5:0] funct);
    return funct[5:2] == 4'b0110;
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Operand/magnitude registers, 2*XLEN accumulator and the per-cycle
// shift-add (multiply) or restoring-subtract (divide) step, plus the final
// sign correction. Sequencing is supplied by muldiv_unit.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            prep,
  input  logic            step,
  input  logic            is_signed,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] a_latched,
  output logic            b_zero,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  logic [XLEN-1:0]   ra_reg, rb_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic              sa_reg, sb_reg;

  logic              neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     sum, diff;
  logic [2*XLEN-1:0] acc_next, product;
  logic [XLEN-1:0]   quot, rem;

  assign a_latched = ra_reg;
  assign b_zero    = (rb_reg == '0);

  // Magnitudes of the raw operands; only meaningful while raw values are held
  always_comb begin
    neg_a = is_signed & ra_reg[XLEN-1];
    neg_b = is_signed & rb_reg[XLEN-1];
    mag_a = neg_a ? (-ra_reg) : ra_reg;
    mag_b = neg_b ? (-rb_reg) : rb_reg;
  end

  // One iteration: multiply adds the multiplicand when the low bit is set and
  // shifts right; divide shifts left and keeps the trial subtraction if it
  // did not borrow. The remainder is always below the divisor, so a borrow
  // shows up in the top bit of the XLEN+1-bit difference.
  always_comb begin
    sum      = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, ra_reg} : '0);
    diff     = acc_reg[2*XLEN-1:XLEN-1] - {1'b0, rb_reg};
    acc_next = {sum, acc_reg[XLEN-1:1]};
    if (is_div) begin
      if (diff[XLEN])
        acc_next = {acc_reg[2*XLEN-2:0], 1'b0};
      else
        acc_next = {diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
    end
  end

  // Operand capture, magnitude conversion and accumulator iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_reg  <= '0;
      rb_reg  <= '0;
      acc_reg <= '0;
      sa_reg  <= 1'b0;
      sb_reg  <= 1'b0;
    end else if (load) begin
      ra_reg <= a;
      rb_reg <= b;
    end else if (prep) begin
      ra_reg  <= mag_a;
      rb_reg  <= mag_b;
      sa_reg  <= neg_a;
      sb_reg  <= neg_b;
      acc_reg <= is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
    end else if (step) begin
      acc_reg <= acc_next;
    end
  end

  // Sign correction: product negated on sign mismatch; quotient negated on
  // sign mismatch, remainder follows the dividend's sign
  always_comb begin
    product = (is_signed & ~is_div & (sa_reg ^ sb_reg)) ? (-acc_reg) : acc_reg;
    quot    = acc_reg[XLEN-1:0];
    rem     = acc_reg[2*XLEN-1:XLEN];
    if (is_div) begin
      res_lo = (is_signed & (sa_reg ^ sb_reg)) ? (-quot) : quot;
      res_hi = (is_signed & sa_reg) ? (-rem) : rem;
    end else begin
      res_lo = product[XLEN-1:0];
      res_hi = product[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS mult/multu/div/divu unit owning HI/LO. A five-state
// sequencer runs XLEN datapath iterations and holds the pipeline via stall
// while an operation is in flight.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  input  logic            mf_req,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            stall
);

  localparam int CW = $clog2(XLEN);

  md_state_e       state_reg, state_next;
  logic [1:0]      op_reg;
  logic [CW-1:0]   cnt_reg;
  logic [XLEN-1:0] hi_reg, lo_reg;

  logic            dp_load, dp_prep, dp_step;
  logic            is_div, is_signed, b_zero, div_by_zero, last_iter;
  logic [XLEN-1:0] a_latched, res_hi, res_lo;

  assign is_div      = op_is_div(op_reg);
  assign is_signed   = op_is_signed(op_reg);
  assign div_by_zero = is_div & b_zero;
  assign last_iter   = (cnt_reg == CW'(XLEN - 1));
  assign dp_load     = (state_reg == ST_IDLE) & start;
  assign dp_prep     = (state_reg == ST_PREP);
  assign dp_step     = (state_reg == ST_CALC);
  assign hi          = hi_reg;
  assign lo          = lo_reg;

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (dp_load),
    .prep      (dp_prep),
    .step      (dp_step),
    .is_signed (is_signed),
    .is_div    (is_div),
    .a         (a),
    .b         (b),
    .a_latched (a_latched),
    .b_zero    (b_zero),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state: divide by zero short-circuits straight to DONE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_PREP;
      ST_PREP:  state_next = div_by_zero ? ST_DONE : ST_CALC;
      ST_CALC:  if (last_iter) state_next = ST_FIXUP;
      ST_FIXUP: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Status outputs; stall holds any HI/LO-touching instruction while busy
  always_comb begin
    busy  = (state_reg != ST_IDLE);
    done  = (state_reg == ST_DONE);
    stall = busy & (start | mf_req | hi_we | lo_we);
  end

  // Latched operation and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg  <= MD_MULT;
      cnt_reg <= '0;
    end else begin
      if (dp_load) op_reg <= op;
      if (dp_prep)      cnt_reg <= '0;
      else if (dp_step) cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // HI/LO: mthi/mtlo only when idle; results land on the PREP (divide by
  // zero) or FIXUP edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (hi_we) hi_reg <= wdata;
          if (lo_we) lo_reg <= wdata;
        end
        ST_PREP: begin
          if (div_by_zero) begin
            hi_reg <= a_latched;
            lo_reg <= '1;
          end
        end
        ST_FIXUP: begin
          hi_reg <= res_hi;
          lo_reg <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule
